seg_dynamic_scan: RTL
=====================

SEG_DYNAMIC_SCAN -- requirements
Module: seg_dynamic_scan

Interface
REQ-001 SHALL have parameter DIGITS, default 6: number of multiplexed digits, legal range 2..8.
REQ-002 SHALL have parameter SLOT_CYC, default 50000: sys_clk cycles per digit slot, minimum 64.
REQ-003 SHALL have parameter GUARD_CYC, default 16: blanking cycles at slot start for ghost suppression, less than SLOT_CYC/2.
REQ-004 SHALL have parameter BLINK_FRAMES, default 83: frames per blink half-period, minimum 1.
REQ-005 SHALL have parameter SEG_ACT_LOW, default 1: when 1, a lit segment is driven 0.
REQ-006 SHALL have parameter SEL_ACT_LOW, default 0: when 1, the selected digit is driven 0.
REQ-007 SHALL have input sys_clk, 1 bit: clock; all logic is on the rising edge.
REQ-008 SHALL have input sys_rst_n, 1 bit: reset, asynchronous, active-low.
REQ-009 SHALL have input digits_in, 4*DIGITS bits: hex nibble per digit; nibble i is digit i, and digit 0 is the least significant.
REQ-010 SHALL have input point, DIGITS bits: decimal point request per digit.
REQ-011 SHALL have input blink_mask, DIGITS bits: digits to blink.
REQ-012 SHALL have input blank_lz, 1 bit: leading-zero blanking enable.
REQ-013 SHALL have input bright, 3 bits: brightness level 0..7.
REQ-014 SHALL have input seg_on, 1 bit: display enable.
REQ-015 SHALL have input load, 1 bit: single-cycle strobe that captures all data inputs.
REQ-016 SHALL have output seg, 8 bits: bit 7 is the decimal point; bits 6..0 are segments g..a.
REQ-017 SHALL have output sel, DIGITS bits: digit select, one-hot when active.
REQ-018 SHALL have output frame_done, 1 bit: one-cycle pulse at the end of each full scan.

Function
REQ-019 load=1 SHALL copy digits_in, point, blink_mask, blank_lz and bright into a staging register.
REQ-020 The staging register SHALL transfer to the display register only on the first cycle of slot 0, so no frame mixes old and new data.
REQ-021 If load and a frame start coincide, the value captured in that cycle SHALL be applied at the following frame start.
REQ-022 Slot counter SHALL count 0..SLOT_CYC-1 and wrap to 0; each wrap SHALL advance the digit index from 0 to DIGITS-1, then back to 0.
REQ-023 frame_done SHALL pulse for one cycle coincident with the slot-counter wrap of digit DIGITS-1.
REQ-024 Digit on-window SHALL be GUARD_CYC <= slot_cnt < GUARD_CYC + ((SLOT_CYC-GUARD_CYC)*(bright+1))/8, computed at elaboration or via a registered threshold; bright=7 gives full slot minus guard.
REQ-025 Outside the on-window, sel SHALL be all inactive and seg all unlit.
REQ-026 Blink phase bit SHALL toggle every BLINK_FRAMES frames.
REQ-027 A digit with its blink_mask bit set SHALL be unlit while the blink phase bit is 1, including its point.
REQ-028 With blank_lz=1, digit i SHALL be unlit when it and every higher digit are 0 and none of them has its point bit set; digit 0 is never blanked.
REQ-029 Nibble decode SHALL cover 0..F: 0-9 standard, A b C d E F.
REQ-030 seg bit 7 SHALL be lit exactly when the point bit of the digit being displayed is set.
REQ-031 seg and sel SHALL be registered outputs with exactly 1 cycle latency from the counter state.
REQ-032 seg_on=0 SHALL drive all outputs unlit/inactive within 1 cycle while the counters keep running.
REQ-033 Polarity SHALL be applied only at the output register.

Reset
REQ-034 On reset: slot counter=0, digit index=0, blink phase=0, staging and display registers=0.
REQ-035 On reset, sel SHALL be all inactive, seg all unlit (0xFF when SEG_ACT_LOW=1), and frame_done=0.
REQ-036 Reset asserted mid-frame SHALL blank outputs immediately, and scanning SHALL restart at digit 0.

Structure
REQ-037 Segment decode constants (0..F) and the unlit/lit polarity helpers SHALL live in the shared package seg_pkg.
REQ-038 The hex-to-segment decode SHALL be a sub-module seg_hex_decode (combinational, 4 bits in, 7 bits out), reused by other display blocks.

Verification
REQ-039 Use DIGITS=6, SLOT_CYC=64, GUARD_CYC=4, BLINK_FRAMES=2. load digits 0x123456, bright=7 -> sel steps 000001..100000, 60 lit cycles per slot, digit 0 shows "6" = 0x82 (active-low); frame_done every 384 cycles.
REQ-040 load 0x000042 with blank_lz=1 and point=0 -> digits 2..5 unlit and digits 0..1 show 2 and 4. Then point[3]=1 -> digits 2..3 show 0 with the DP on digit 3, and digits 4..5 stay unlit.
REQ-041 bright=0 -> on-window is cycles 4..10 of each slot (7 cycles); sel is inactive for cycles 0..3 and 11..63.
REQ-042 blink_mask=000001 -> digit 0 lit for 2 frames, unlit for 2 frames, repeating; other digits are unaffected.
REQ-043 load pulsed mid-frame with new data -> old data is shown until slot 0 of the next frame, and no frame mixes values.
REQ-044 sys_rst_n low at slot 3 for 1 cycle -> outputs are unlit within the same cycle, and after release the scan restarts at digit 0 with frame_done first seen 384 cycles later.

Source files
------------

// File: rtl/seg_pkg.sv
// seg_pkg: shared 7-segment glyph table and drive-polarity helpers.
// Glyphs are active-high, bit order g..a.
package seg_pkg;

    localparam logic [15:0][6:0] SEG_LUT = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    function automatic logic [7:0] seg_drive(
        input logic [7:0] lit,
        input bit         act_low
    );
        return act_low ? ~lit : lit;
    endfunction

    function automatic logic [7:0] seg_unlit(input bit act_low);
        return seg_drive(8'h00, act_low);
    endfunction

endpackage

// File: rtl/seg_hex_decode.sv
// seg_hex_decode: combinational hex nibble to active-high g..a glyph.
module seg_hex_decode
    import seg_pkg::*;
(
    input  logic [3:0] nib_i,
    output logic [6:0] seg_o
);

    assign seg_o = SEG_LUT[nib_i];

endmodule

// File: rtl/seg_dynamic_scan.sv
// seg_dynamic_scan: multiplexed 7-segment scanner with frame-aligned
// data update, guard blanking, brightness window, blink and LZ blanking.
module seg_dynamic_scan
    import seg_pkg::*;
#(
    parameter int DIGITS       = 6,
    parameter int SLOT_CYC     = 50000,
    parameter int GUARD_CYC    = 16,
    parameter int BLINK_FRAMES = 83,
    parameter int SEG_ACT_LOW  = 1,
    parameter int SEL_ACT_LOW  = 0
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,
    input  logic [4*DIGITS-1:0]   digits_in,
    input  logic [DIGITS-1:0]     point,
    input  logic [DIGITS-1:0]     blink_mask,
    input  logic                  blank_lz,
    input  logic [2:0]            bright,
    input  logic                  seg_on,
    input  logic                  load,
    output logic [7:0]            seg,
    output logic [DIGITS-1:0]     sel,
    output logic                  frame_done
);

    localparam int SCW = $clog2(SLOT_CYC);
    localparam int DW  = $clog2(DIGITS);
    localparam int FW  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam bit SEGL = (SEG_ACT_LOW != 0);
    localparam logic [DIGITS-1:0] SELX = (SEL_ACT_LOW != 0) ? '1 : '0;

    typedef struct packed {
        logic [4*DIGITS-1:0] digits;
        logic [DIGITS-1:0]   point;
        logic [DIGITS-1:0]   blink;
        logic                blz;
        logic [2:0]          bright;
    } disp_t;

    function automatic logic [SCW:0] on_end(input logic [2:0] b);
        return (SCW+1)'(GUARD_CYC +
            ((SLOT_CYC - GUARD_CYC) * (int'(b) + 1)) / 8);
    endfunction

    logic [SCW-1:0]    slot_q, slot_d;
    logic [DW-1:0]     dig_q, dig_d;
    logic [FW-1:0]     fcnt_q, fcnt_d;
    logic              phase_q, phase_d;
    disp_t             stg_q, stg_d, dsp_q, dsp_d;
    logic [SCW:0]      thr_q, thr_d;
    logic [7:0]        seg_q, seg_d;
    logic [DIGITS-1:0] sel_q, sel_d;
    logic              fd_q;
    logic              wrap, last, fstart, fend, in_win, lit, run;
    logic [DIGITS-1:0] lz;
    logic [3:0]        nib;
    logic [6:0]        glyph;

    seg_hex_decode u_dec (
        .nib_i (nib),
        .seg_o (glyph)
    );

    always_comb begin
        wrap    = (slot_q == SCW'(SLOT_CYC - 1));
        last    = (dig_q == DW'(DIGITS - 1));
        fstart  = (slot_q == '0) && (dig_q == '0);
        fend    = wrap && last;
        slot_d  = wrap ? '0 : slot_q + SCW'(1);
        dig_d   = dig_q;
        fcnt_d  = fcnt_q;
        phase_d = phase_q;
        if (wrap) dig_d = last ? '0 : dig_q + DW'(1);
        if (fend) begin
            if (fcnt_q == FW'(BLINK_FRAMES - 1)) begin
                fcnt_d  = '0;
                phase_d = ~phase_q;
            end else begin
                fcnt_d = fcnt_q + FW'(1);
            end
        end
        stg_d = stg_q;
        if (load) stg_d = '{digits: digits_in, point: point,
                            blink: blink_mask, blz: blank_lz,
                            bright: bright};
        // The display path uses the next-state copy so slot 0 cycle 0
        // already shows the new frame's data.
        dsp_d = fstart ? stg_q : dsp_q;
        thr_d = fstart ? on_end(stg_q.bright) : thr_q;
        run = dsp_d.blz;
        lz  = '0;
        for (int i = DIGITS - 1; i > 0; i--) begin
            run   = run && (dsp_d.digits[4*i +: 4] == 4'h0) &&
                    !dsp_d.point[i];
            lz[i] = run;
        end
        nib    = dsp_d.digits[4*dig_q +: 4];
        in_win = ({1'b0, slot_q} >= (SCW+1)'(GUARD_CYC)) &&
                 ({1'b0, slot_q} < thr_d);
        lit    = seg_on && in_win && !lz[dig_q] &&
                 !(dsp_d.blink[dig_q] && phase_q);
        seg_d  = lit ? seg_drive({dsp_d.point[dig_q], glyph}, SEGL)
                     : seg_unlit(SEGL);
        sel_d  = (lit ? (DIGITS'(1) << dig_q) : '0) ^ SELX;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            slot_q  <= '0;
            dig_q   <= '0;
            fcnt_q  <= '0;
            phase_q <= 1'b0;
            stg_q   <= '0;
            dsp_q   <= '0;
            thr_q   <= on_end(3'd0);
            seg_q   <= seg_unlit(SEGL);
            sel_q   <= SELX;
            fd_q    <= 1'b0;
        end else begin
            slot_q  <= slot_d;
            dig_q   <= dig_d;
            fcnt_q  <= fcnt_d;
            phase_q <= phase_d;
            stg_q   <= stg_d;
            dsp_q   <= dsp_d;
            thr_q   <= thr_d;
            seg_q   <= seg_d;
            sel_q   <= sel_d;
            fd_q    <= fend;
        end
    end

    assign seg        = seg_q;
    assign sel        = sel_q;
    assign frame_done = fd_q;

endmodule
